led_pattern_seq: RTL

- Consumes the slow square wave from the blinker stage (blink, bit 24 of its free-running counter) as a step clock-enable.
- Detects each rising edge of that wave and advances one of four LED patterns.
- Drives the board LED bank through a global-brightness PWM gate.
- Sits directly downstream of the blinker; led connects to the top-level LED pins.

---
 rtl/led_pattern_seq.sv | 112 +++++++++++
 1 files changed

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: steps one of four patterns on each rising edge of the
// slow blinker wave and gates the LED bank with a global-brightness PWM.
module led_pattern_seq #(
  parameter int LED_COUNT = 8,
  parameter int PWM_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step_in,
  input  logic [1:0]           mode,
  input  logic [PWM_BITS-1:0]  bright,
  output logic [LED_COUNT-1:0] led
);

  localparam int POS_W  = $clog2(LED_COUNT);
  localparam int FILL_W = $clog2(LED_COUNT + 1);
  localparam logic [POS_W-1:0]  POS_MAX  = POS_W'(LED_COUNT - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(LED_COUNT);

  typedef enum logic [1:0] {
    MODE_CHASE  = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_BINARY = 2'd2,
    MODE_FILL   = 2'd3
  } mode_e;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  logic                 step_prev;
  mode_e                mode_q;
  logic [POS_W-1:0]     pos, pos_d;
  dir_e                 dir, dir_d;
  logic [LED_COUNT-1:0] cnt, cnt_d;
  logic [FILL_W-1:0]    fill, fill_d;
  logic [PWM_BITS-1:0]  pwm_cnt, bright_q;

  logic                 step_evt, mode_chg, pwm_on;
  logic [LED_COUNT-1:0] pattern;

  assign step_evt = step_in & ~step_prev;
  assign mode_chg = (mode != mode_q);
  assign pwm_on   = (pwm_cnt < bright_q);

  // Pattern state next-value logic; a mode change outranks a coincident step.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    pos_d  = pos;
    dir_d  = dir;
    cnt_d  = cnt;
    fill_d = fill;
    if (mode_chg) begin
      pos_d  = '0;
      dir_d  = DIR_UP;
      cnt_d  = '0;
      fill_d = '0;
    end else if (step_evt) begin
      unique case (mode_q)
        MODE_CHASE:  pos_d = (pos == POS_MAX) ? '0 : pos + POS_W'(1);
        MODE_BOUNCE: begin
          if (dir == DIR_UP) begin
            pos_d = pos + POS_W'(1);
            if (pos_d == POS_MAX) dir_d = DIR_DOWN;
          end else begin
            pos_d = pos - POS_W'(1);
            if (pos_d == '0) dir_d = DIR_UP;
          end
        end
        MODE_BINARY: cnt_d  = cnt + LED_COUNT'(1);
        MODE_FILL:   fill_d = (fill == FILL_MAX) ? '0 : fill + FILL_W'(1);
      endcase
    end
  end

  // Pattern decoded from the already-updated state, so a step shows one edge later.
  always_comb begin
    pattern = '0;
    unique case (mode_q)
      MODE_CHASE, MODE_BOUNCE: pattern[pos] = 1'b1;
      MODE_BINARY:             pattern = cnt;
      MODE_FILL: begin
        for (int i = 0; i < LED_COUNT; i++) pattern[i] = (FILL_W'(i) < fill);
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      led       <= '0;
      step_prev <= 1'b1;
      mode_q    <= MODE_CHASE;
      pos       <= '0;
      dir       <= DIR_UP;
      cnt       <= '0;
      fill      <= '0;
      pwm_cnt   <= '0;
      bright_q  <= '0;
    end else begin
      step_prev <= step_in;
      mode_q    <= mode_e'(mode);
      pos       <= pos_d;
      dir       <= dir_d;
      cnt       <= cnt_d;
      fill      <= fill_d;
      pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
      // Duty only changes at the period boundary to keep the on-window glitch free.
      if (pwm_cnt == '1) bright_q <= bright;
      led       <= pwm_on ? pattern : '0;
    end
  end

endmodule
